sevenseg_scan: RTL and testbench
================================

// Module: sevenseg_scan
// PURPOSE
//  Multiplexed N-digit 7-segment display driver: hex decode per digit, per-digit decimal point,
//  leading-zero blanking, PWM brightness and anti-ghosting guard time. Sits between the counter/
//  datapath logic and the board's common-anode display pins; successor to single-digit hex decode.
//  Segment encoding, active-low: seg[7..0] = g,f,e,d,c,b,a,dp.
// PARAMETERS
//  DIGITS        4   number of digits; digit 0 = least significant, rightmost
//  SLOT_LOG2     10  each digit slot lasts 2**SLOT_LOG2 clk cycles; must be >= BRIGHT_W+1
//  BRIGHT_W      4   brightness control width
//  GUARD         2   cycles at slot start with all anodes off; must be < 2**(SLOT_LOG2-BRIGHT_W)
// PORTS
//  clk         in   1           system clock; one clock domain
//  rst         in   1           synchronous, active-high reset
//  value       in   4*DIGITS    hex nibbles; nibble i = value[4i+3:4i] drives digit i
//  dp_in       in   DIGITS      dp_in[i]=1 lights the decimal point of digit i
//  load        in   1           1-cycle strobe: capture value/dp_in into pending register
//  blank_lz    in   1           1 = suppress leading zeros
//  brightness  in   BRIGHT_W    on-time per slot; 0 = dark
//  seg         out  8           segment cathodes, active-low (registered)
//  an          out  DIGITS      digit anode enables, active-low, at most one low (registered)
//  frame_tick  out  1           1-cycle pulse in the cycle after digit DIGITS-1's slot ends
// BEHAVIOUR
//  - Reset: seg=8'hFF, an=all 1, frame_tick=0; slot_cnt=0, digit idx=0, pending and display
//    registers=0, pending_valid=0. Reset mid-scan takes effect on the next edge and restarts slot 0.
//  - slot_cnt counts 0..2**SLOT_LOG2-1 and wraps; on wrap idx advances, DIGITS-1 -> 0.
//  - Frame boundary = slot_cnt wrap while idx==DIGITS-1. frame_tick is high for the next cycle.
//  - load: copies value/dp_in into pending and sets pending_valid; a later load overwrites it.
//    At a frame boundary, if pending_valid, display<=pending and pending_valid clears.
//    load in the boundary cycle: that load's data goes straight to display. Updates never tear.
//  - brightness is sampled into a slot register when slot_cnt==0.
//  - Anode on when slot_cnt>=GUARD && slot_cnt[SLOT_LOG2-1 -: BRIGHT_W] < bright_q.
//    Max duty is (2**BRIGHT_W-1)/2**BRIGHT_W minus the guard.
//  - Output latency: seg/an are registered and reflect the slot_cnt/idx value of the previous cycle.
//  - Decode: 0-F standard hex glyphs (b,d lowercase); dp segment = ~display_dp[idx].
//  - Leading-zero blank: digit i>0 is blanked (seg=8'hFF) when blank_lz, the nibbles of digits
//    DIGITS-1..i are all zero, and the dp of each of those digits is 0. Digit 0 is never blanked.
//    A blanked digit still cycles its anode; only seg is forced off.
//  - seg=8'hFF whenever every anode is off, including guard and PWM-off time.
// STRUCTURE
//  - Shared package sevenseg_pkg: localparams for the 16 glyph patterns (active-low 7-bit, no
//    dp), SEG_OFF=8'hFF, and the segment bit-position constants.
//  - One sub-module: seg7_decode (combinational nibble+dp -> 8-bit pattern, from the package).
//  - Top level holds the counters, pending/display registers, blanking mask and output regs.
// TESTING  (DIGITS=4, SLOT_LOG2=4, BRIGHT_W=2, GUARD=1; 16-cycle slots, 64-cycle frame)
//  1 rst high 3 cycles, then rst pulsed mid-slot 2 -> seg=8'hFF, an=4'hF, frame_tick=0 the next
//    cycle; scan restarts at digit 0.
//  2 load value=16'h12AF, dp_in=0, brightness=3 -> from the next frame, an=1110 shows seg=8'h1D,
//    1101 shows 8'h11, 1011 shows 8'h49, 0111 shows 8'hF3.
//  3 brightness=2 -> each anode low exactly 7 consecutive cycles (slot_cnt 1..7) per slot, seg=FF
//    otherwise; brightness=0 -> an stays 4'hF all frame.
//  4 blank_lz=1, value=16'h0040, dp=0 -> digits 3 and 2 show seg=8'hFF, digit 1 shows 8'h33, digit 0
//    shows 8'h81. With dp_in=4'b0100, digit 2 shows 8'h80. value=0 -> digit 0 shows 8'h81, others FF.
//  5 load mid-frame -> display unchanged until the boundary. Two loads in one frame -> the last wins.
//    load in the boundary cycle -> it shows in the new frame. frame_tick: one pulse every 64 cycles.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared segment layout and hex glyph patterns for the seven-segment driver.
package sevenseg_pkg;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int SEG_DP = 0;
    localparam int SEG_A  = 1;
    localparam int SEG_G  = 7;
    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble plus decimal point to active-low 8-bit segment pattern.
module seg7_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);
    logic [6:0] glyph;

    always_comb begin
        case (nib)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
    end

    always_comb begin
        seg = SEG_OFF;
        seg[SEG_G:SEG_A] = glyph;
        seg[SEG_DP] = ~dp;
    end
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed N-digit common-anode display driver with PWM brightness,
// guard time, leading-zero blanking and frame-synchronous (tear-free) updates.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SLOT_LOG2 = 10,
    parameter int BRIGHT_W  = 4,
    parameter int GUARD     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [SLOT_LOG2-1:0] slot_cnt;
    logic [IW-1:0]        idx;
    logic [BRIGHT_W-1:0]  bright_q;
    logic [4*DIGITS-1:0]  pend_val, disp_val;
    logic [DIGITS-1:0]    pend_dp, disp_dp, lz;
    logic                 pend_valid, last_digit, boundary, on, run;
    logic [7:0]           dec_seg;

    assign last_digit = idx == IW'(DIGITS - 1);
    assign boundary   = &slot_cnt && last_digit;
    assign on = slot_cnt >= SLOT_LOG2'(GUARD) && slot_cnt[SLOT_LOG2-1 -: BRIGHT_W] < bright_q;

    // A digit blanks only while every more-significant digit, itself included, is a bare zero.
    always_comb begin
        lz = '0;
        run = blank_lz;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run = run && disp_val[4*i +: 4] == 4'h0 && !disp_dp[i];
            lz[i] = run;
        end
    end

    seg7_decode u_dec (
        .nib (disp_val[4*int'(idx) +: 4]),
        .dp  (disp_dp[idx]),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            idx        <= '0;
            bright_q   <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            seg        <= SEG_OFF;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            slot_cnt   <= slot_cnt + 1'b1;
            frame_tick <= boundary;
            if (&slot_cnt)
                idx <= last_digit ? '0 : idx + 1'b1;
            if (slot_cnt == '0)
                bright_q <= brightness;
            // Display only changes at the frame boundary so a frame never mixes old and new data.
            if (boundary) begin
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_in;
                end else if (pend_valid) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
            an  <= on ? ~(DIGITS'(1) << idx) : '1;
            seg <= on && !lz[idx] ? dec_seg : SEG_OFF;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed vectors for the scan driver with 16-cycle slots and a 64-cycle frame.
module tb_sevenseg_scan;
    localparam int DIGITS = 4, SLOT_LOG2 = 4, BRIGHT_W = 2, GUARD = 1;

    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [1:0]  brightness = 2'd3;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    int          checks = 0, errors = 0;
    logic [7:0]  seg_s [64];
    logic [3:0]  an_s  [64];
    logic [63:0] ft_s;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [1:0]  br;
        logic        blz;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    sevenseg_scan #(.DIGITS(DIGITS), .SLOT_LOG2(SLOT_LOG2), .BRIGHT_W(BRIGHT_W), .GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
        .brightness(brightness), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Entered on the negedge of a cycle whose counter sits at frame position 0; sample t=1..64
    // holds the outputs computed from position t-1. Loads are asserted during cycle l1/l2.
    task automatic run_frame(input int l1, input logic [15:0] v1, input logic [3:0] d1,
                             input int l2, input logic [15:0] v2, input logic [3:0] d2);
        for (int t = 1; t <= 64; t++) begin
            @(negedge clk);
            an_s[t-1] = an;
            seg_s[t-1] = seg;
            ft_s[t-1] = frame_tick;
            load = t == l1 || t == l2;
            if (t == l1) begin value = v1; dp_in = d1; end
            if (t == l2) begin value = v2; dp_in = d2; end
        end
        chk("frame_tick", ft_s, 64'h8000_0000_0000_0000);
    endtask

    task automatic check_frame(input string name, input int br, input logic [31:0] exp);
        int d, c;
        logic on;
        logic [3:0] ea;
        logic [7:0] es;
        for (int p = 0; p < 64; p++) begin
            d = p / 16;
            c = p % 16;
            on = c >= GUARD && c / 4 < br;
            ea = on ? ~(4'b0001 << d) : 4'hF;
            es = on ? exp[8*d +: 8] : 8'hFF;
            chk($sformatf("%s pos%0d an_seg", name, p), {52'd0, an_s[p], seg_s[p]}, {52'd0, ea, es});
        end
    endtask

    initial begin
        vecs[0] = '{16'h12AF, 4'b0000, 2'd3, 1'b0, 32'hF349111D};
        vecs[1] = '{16'h12AF, 4'b0000, 2'd2, 1'b0, 32'hF349111D};
        vecs[2] = '{16'h12AF, 4'b0000, 2'd0, 1'b0, 32'hF349111D};
        vecs[3] = '{16'h12AF, 4'b0000, 2'd1, 1'b0, 32'hF349111D};
        vecs[4] = '{16'h0040, 4'b0000, 2'd3, 1'b1, 32'hFFFF3381};
        vecs[5] = '{16'h0040, 4'b0100, 2'd3, 1'b1, 32'hFF803381};
        vecs[6] = '{16'h0000, 4'b0000, 2'd3, 1'b1, 32'hFFFFFF81};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset an", 64'(an), 64'hF);
        chk("reset seg", 64'(seg), 64'hFF);
        chk("reset frame_tick", 64'(frame_tick), 64'h0);
        rst = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            load = t == 10;
            if (t == 10) value = 16'h12AF;
        end
        chk("pre-reset an", 64'(an), 64'hB);
        chk("pre-reset seg", 64'(seg), 64'h81);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midscan reset an", 64'(an), 64'hF);
        chk("midscan reset seg", 64'(seg), 64'hFF);
        chk("midscan reset frame_tick", 64'(frame_tick), 64'h0);
        run_frame(-1, '0, '0, -1, '0, '0);
        check_frame("after reset", 3, 32'h81818181);
        run_frame(-1, '0, '0, -1, '0, '0);
        check_frame("pending cleared", 3, 32'h81818181);
        for (int i = 0; i < 7; i++) begin
            brightness = vecs[i].br;
            blank_lz = vecs[i].blz;
            run_frame(5, vecs[i].val, vecs[i].dp, -1, '0, '0);
            run_frame(-1, '0, '0, -1, '0, '0);
            check_frame($sformatf("vec%0d", i), vecs[i].br, vecs[i].exp);
        end
        blank_lz = 1'b0;
        brightness = 2'd3;
        run_frame(10, 16'h3456, 4'b0000, 30, 16'h789B, 4'b0000);
        check_frame("midframe load held", 3, 32'h81818181);
        run_frame(63, 16'hCDE0, 4'b0001, -1, '0, '0);
        check_frame("last load wins", 3, 32'hF1012107);
        run_frame(-1, '0, '0, -1, '0, '0);
        check_frame("boundary load", 3, 32'h8D430D80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
